s2mm_128: RTL and testbench
===========================

// Module: s2mm_128
// PURPOSE
//  Stream-to-memory DMA stage: consumes a 128b AXI-Stream and writes each beat into a
//  128b-wide BRAM at consecutive word addresses. Sits downstream of the MM2S engine in
//  the DMA loopback path and is the write-side twin of it. Checks stream length
//  (tlast position) against the programmed byte count and flags mismatches.
// PARAMETERS
//  ADDR_W      12   BRAM word-address width (one word = 128b = 16 bytes)
// PORTS
//  clk         in   1        single clock, all logic rising-edge
//  rstn        in   1        asynchronous active-low reset
//  start       in   1        1-cycle request; sampled only when busy=0
//  byte_len    in   32       bytes to receive; beats = ceil(byte_len/16)
//  base        in   ADDR_W   first BRAM word address
//  busy        out  1        transfer in progress
//  done        out  1        1-cycle completion pulse
//  err_short   out  1        tlast arrived before byte_len exhausted (sticky to next start)
//  err_long    out  1        byte_len exhausted before tlast (sticky to next start)
//  beats_wr    out  32       beats written to BRAM in current/last transfer
//  wr_en       out  1        BRAM write strobe
//  wr_addr     out  ADDR_W   BRAM write address
//  wr_data     out  128      BRAM write data
//  s_tdata     in   128      AXIS data
//  s_tvalid    in   1        AXIS valid
//  s_tready    out  1        AXIS ready (registered)
//  s_tlast     in   1        AXIS last beat
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; internal bytes_left/cur_addr 0. Reset mid-transfer
//   aborts immediately; beats already written stay in BRAM.
//  FSM IDLE->RUN->(DRAIN)->FIN->IDLE.
//  IDLE: s_tready=0. start=1: busy<=1, bytes_left<=byte_len, cur_addr<=base,
//   beats_wr<=0, err_*<=0. byte_len=0 -> go FIN directly (no beat accepted).
//   Otherwise s_tready<=1, go RUN.
//  RUN: beat accepted when s_tvalid&&s_tready. Per beat: wr_en<=1, wr_addr<=cur_addr,
//   wr_data<=s_tdata (write issued cycle after acceptance), cur_addr<=cur_addr+1 (wraps
//   mod 2^ADDR_W), beats_wr+1, bytes_left-=16 saturating at 0. last_exp=(bytes_left<=16).
//   - last_exp & tlast: s_tready<=0, go FIN.
//   - !last_exp & tlast: err_short<=1, s_tready<=0, go FIN.
//   - last_exp & !tlast: err_long<=1, s_tready stays 1, go DRAIN.
//  DRAIN: beats accepted and discarded (no wr_en, beats_wr frozen) until tlast beat
//   accepted; then s_tready<=0, go FIN.
//  s_tready deasserts on the same edge that accepts the final beat: no extra beat taken.
//  wr_en otherwise 0; wr_addr/wr_data hold last value when wr_en=0.
//  FIN: one cycle; final wr_en (if any) is committed at its end; on exit busy<=0 and
//   done<=1 (done high the cycle after the final wr_en, so BRAM data is committed).
//  Throughput: 1 beat/cycle with continuous tvalid; tvalid gaps just stall.
//  start while busy ignored. start in the done cycle is accepted (busy=0 then).
//  beats_wr and err_* hold until next accepted start.
// STRUCTURE
//  Shared pkg dma_axis_pkg: DATA_W=128, WBYTES=16, FSM state encoding (IDLE/RUN/DRAIN/
//  FIN), common with the MM2S engine. Single flat module; no sub-module warranted.
// TESTING
//  1 byte_len=64, base=0x010, 4 beats back-to-back, tlast on #4 -> wr 0x010..0x013 in 4
//    consecutive cycles, done 1 cycle after last wr_en, beats_wr=4, no err.
//  2 byte_len=40 -> 3 beats (tlast #3) written, done, no err; tready low after #3.
//  3 byte_len=64, tlast on #2 -> 2 writes, err_short=1, err_long=0, done, beats_wr=2.
//  4 byte_len=32, 5 beats tlast on #5 -> 2 writes, beats 3-5 accepted without wr_en,
//    err_long=1, done after #5.
//  5 base=0xFFE, byte_len=64, random tvalid gaps -> addrs 0xFFE,0xFFF,0x000,0x001; data
//    order preserved; start pulsed mid-transfer ignored.
//  6 byte_len=0 -> done 2 cycles after start, no tready/wr_en; rstn low mid-RUN -> all
//    outputs 0 next cycle, new start after release works; loopback with MM2S matches.

Source files
------------

// File: rtl/dma_axis_pkg.sv
// Shared DMA stream definitions: data width, word size and engine FSM encoding.
// No logic; consumed by both the MM2S and S2MM engines.
// No flow control of its own.
package dma_axis_pkg;
    localparam int DATA_W = 128;
    localparam int WBYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } dma_state_e;
endpackage

// File: rtl/s2mm_128.sv
// Stream-to-memory engine: writes each accepted 128b AXIS beat to consecutive BRAM words.
// Latency: write issued the cycle after beat acceptance; done one cycle after the final write.
// Backpressure: registered s_tready, high only in RUN/DRAIN; dropped on the edge taking the last beat.
module s2mm_128
    import dma_axis_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [31:0]       byte_len,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_long,
    output logic [31:0]       beats_wr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast
);

    dma_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic [31:0]       beats_wr_q, beats_wr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              tready_q, tready_d;
    logic [31:0]       bytes_left_q, bytes_left_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    logic accept;
    logic last_exp;

    assign accept   = s_tvalid && tready_q;
    // This beat uses up the remaining byte budget (partial final word counts as a whole beat).
    assign last_exp = (bytes_left_q <= 32'(WBYTES));

    // Next-state, datapath and output computation; everything holds unless a case overrides it.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_short_d  = err_short_q;
        err_long_d   = err_long_q;
        beats_wr_d   = beats_wr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        tready_d     = tready_q;
        bytes_left_d = bytes_left_q;
        cur_addr_d   = cur_addr_q;

        case (state_q)
            ST_IDLE: begin
                tready_d = 1'b0;
                if (start) begin
                    busy_d       = 1'b1;
                    bytes_left_d = byte_len;
                    cur_addr_d   = base;
                    beats_wr_d   = 32'd0;
                    err_short_d  = 1'b0;
                    err_long_d   = 1'b0;
                    if (byte_len == 32'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        tready_d = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = cur_addr_q;
                    wr_data_d    = s_tdata;
                    cur_addr_d   = cur_addr_q + ADDR_W'(1);
                    beats_wr_d   = beats_wr_q + 32'd1;
                    bytes_left_d = last_exp ? 32'd0 : bytes_left_q - 32'(WBYTES);
                    if (s_tlast) begin
                        err_short_d = !last_exp;
                        tready_d    = 1'b0;
                        state_d     = ST_FIN;
                    end else if (last_exp) begin
                        err_long_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Surplus beats are swallowed so the upstream stream is left aligned on a packet boundary.
                if (accept && s_tlast) begin
                    tready_d = 1'b0;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            beats_wr_q   <= 32'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            tready_q     <= 1'b0;
            bytes_left_q <= 32'd0;
            cur_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            beats_wr_q   <= beats_wr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tready_q     <= tready_d;
            bytes_left_q <= bytes_left_d;
            cur_addr_q   <= cur_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign beats_wr  = beats_wr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign s_tready  = tready_q;

endmodule

// File: tb/tb_s2mm_128.sv
// Directed bench for s2mm_128: drives AXIS bursts, records BRAM writes, checks against hand values.
// Latency checks are relative to a free-running cycle counter.
// Stream driver honours s_tready and can insert random tvalid gaps.
module tb_s2mm_128;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   byte_len = 32'd0;
    logic [AW-1:0] base = '0;
    logic          busy, done, err_short, err_long, wr_en, s_tready;
    logic [31:0]   beats_wr;
    logic [AW-1:0] wr_addr;
    logic [127:0]  wr_data;
    logic [127:0]  s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;

    s2mm_128 #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .byte_len(byte_len), .base(base),
        .busy(busy), .done(done), .err_short(err_short), .err_long(err_long),
        .beats_wr(beats_wr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int rdy_cnt = 0;
    logic [127:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wa_q[$];
    logic [127:0]  wd_q[$];
    int            wc_q[$];

    always @(posedge clk) cyc = cyc + 1;

    // Passive monitor: BRAM model, write log, done and handshake bookkeeping.
    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (s_tvalid && s_tready) acc_cnt = acc_cnt + 1;
        if (s_tready) rdy_cnt = rdy_cnt + 1;
    end

    function automatic logic [127:0] mkdat(input int t, input int i);
        return {4{t[15:0], i[15:0]}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        acc_cnt = 0;
        rdy_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] len, input logic [AW-1:0] b);
        start = 1'b1;
        byte_len = len;
        base = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends n beats of tag t with tlast on the final one; optional gaps and a stray start on beat 2.
    task automatic send_burst(input int t, input int n, input bit gaps, input bit poke);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            s_tdata = mkdat(t, i);
            s_tlast = (i == n - 1);
            s_tvalid = 1'b1;
            if (poke && i == 2) begin
                start = 1'b1;
                byte_len = 32'd16;
                base = 12'h123;
            end
            w = 0;
            while (!s_tready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) chk("tready_timeout", 1'b0, 1'b1);
            @(negedge clk);
            start = 1'b0;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int prev = done_cnt;
        int w = 0;
        while (done_cnt == prev && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 1'(done_cnt != prev), 1'b1);
    endtask

    initial begin
        int s;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_wren", wr_en, 1'b0);
        chk("rst_beats", beats_wr, 32'd0);
        chk("rst_addr_data", {wr_addr, wr_data}, '0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: 64 bytes, four back-to-back beats at 0x010
        clear_log();
        do_start(32'd64, 12'h010);
        chk("t1_busy", busy, 1'b1);
        send_burst(1, 4, 1'b0, 1'b0);
        wait_done("t1_done");
        chk("t1_nwr", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", wa_q[i], 12'h010 + 12'(i));
            chk("t1_data", wd_q[i], mkdat(1, i));
            chk("t1_cyc", wc_q[i], wc_q[0] + i);
        end
        chk("t1_done_lat", done_cyc, wc_q[3] + 1);
        chk("t1_beats", beats_wr, 32'd4);
        chk("t1_err", {err_short, err_long}, 2'b00);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_idle", busy, 1'b0);

        // 2: 40 bytes -> 3 beats, tready falls with the last one
        clear_log();
        do_start(32'd40, 12'h100);
        send_burst(2, 3, 1'b0, 1'b0);
        chk("t2_tready_low", s_tready, 1'b0);
        wait_done("t2_done");
        chk("t2_nwr", wa_q.size(), 3);
        chk("t2_last_addr", wa_q[2], 12'h102);
        chk("t2_beats", beats_wr, 32'd3);
        chk("t2_err", {err_short, err_long}, 2'b00);
        chk("t2_acc", acc_cnt, 3);

        // 3: 64 bytes but tlast on beat 2
        clear_log();
        do_start(32'd64, 12'h200);
        send_burst(3, 2, 1'b0, 1'b0);
        wait_done("t3_done");
        chk("t3_nwr", wa_q.size(), 2);
        chk("t3_beats", beats_wr, 32'd2);
        chk("t3_err", {err_short, err_long}, 2'b10);

        // 4: 32 bytes, five beats -> two written, three drained
        clear_log();
        do_start(32'd32, 12'h300);
        send_burst(4, 5, 1'b0, 1'b0);
        chk("t4_tready_low", s_tready, 1'b0);
        wait_done("t4_done");
        chk("t4_nwr", wa_q.size(), 2);
        chk("t4_data1", wd_q[1], mkdat(4, 1));
        chk("t4_acc", acc_cnt, 5);
        chk("t4_beats", beats_wr, 32'd2);
        chk("t4_err", {err_short, err_long}, 2'b01);
        chk("t4_sticky", err_long, 1'b1);

        // 5: address wrap with tvalid gaps and a stray start mid-transfer
        clear_log();
        do_start(32'd64, 12'hFFE);
        send_burst(5, 4, 1'b1, 1'b1);
        wait_done("t5_done");
        chk("t5_nwr", wa_q.size(), 4);
        chk("t5_a0", wa_q[0], 12'hFFE);
        chk("t5_a1", wa_q[1], 12'hFFF);
        chk("t5_a2", wa_q[2], 12'h000);
        chk("t5_a3", wa_q[3], 12'h001);
        for (int i = 0; i < 4; i++) chk("t5_data", wd_q[i], mkdat(5, i));
        chk("t5_beats", beats_wr, 32'd4);
        chk("t5_err", {err_short, err_long}, 2'b00);

        // 6a: zero length completes without touching the stream
        clear_log();
        s = cyc;
        do_start(32'd0, 12'h400);
        wait_done("t6_done");
        chk("t6_done_lat", done_cyc, s + 2);
        chk("t6_no_tready", rdy_cnt, 0);
        chk("t6_no_wr", wa_q.size(), 0);
        chk("t6_beats", beats_wr, 32'd0);

        // 6b: reset in the middle of a transfer
        clear_log();
        do_start(32'd64, 12'h500);
        send_burst(6, 2, 1'b0, 1'b0);
        chk("t6_mid_busy", busy, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctl", {busy, done, err_short, err_long, wr_en, s_tready}, 6'd0);
        chk("t6_rst_beats", beats_wr, 32'd0);
        chk("t6_rst_addr_data", {wr_addr, wr_data}, '0);
        rstn = 1'b1;
        @(negedge clk);
        clear_log();
        do_start(32'd32, 12'h600);
        send_burst(7, 2, 1'b0, 1'b0);
        wait_done("t6_re_done");
        chk("t6_re_nwr", wa_q.size(), 2);
        chk("t6_re_addr", wa_q[1], 12'h601);
        chk("t6_re_beats", beats_wr, 32'd2);

        // Memory readback of earlier transfers (what the MM2S side would stream back)
        for (int i = 0; i < 4; i++) chk("rb_t1", mem[12'h010 + 12'(i)], mkdat(1, i));
        chk("rb_t5_wrap", mem[12'h000], mkdat(5, 2));
        chk("rb_t6_keep", mem[12'h501], mkdat(6, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
